// File: rtl/button_debounce_encoder.sv
// Synchronises, debounces and encodes four push-buttons into one-cycle one-hot press pulses.
// Optional macro MULTI_PRESS_REJECT_EN: reject multi-button presses with a pressError pulse.
module button_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] rawButton,
    output logic [3:0] buttonOut,
    output logic       pressValid,
    output logic [1:0] pressCode,
    output logic       pressError,
    output logic       busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    stable_q, stable_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    state_t        state_q, state_d;
    logic [3:0]    button_out_q, button_out_d;
    logic          press_valid_q, press_valid_d;
    logic [1:0]    press_code_q, press_code_d;
    logic          press_error_q, press_error_d;

    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Next-state logic: synchroniser, per-bit debounce counters and the press FSM.
    always_comb begin
        sync1_d       = rawButton;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        button_out_d  = 4'b0000;
        press_valid_d = 1'b0;
        press_code_d  = 2'd0;
        press_error_d = 1'b0;

        // Any cycle of agreement restarts the count, so short bounces never flip stable.
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (enable && (stable_q != 4'b0000)) begin
                    state_d = HELD;
`ifdef MULTI_PRESS_REJECT_EN
                    if ((stable_q & (stable_q - 4'd1)) != 4'b0000) begin
                        press_error_d = 1'b1;
                    end else begin
                        button_out_d  = 4'b0001 << lowest_index(stable_q);
                        press_valid_d = 1'b1;
                        press_code_d  = lowest_index(stable_q);
                    end
`else
                    button_out_d  = 4'b0001 << lowest_index(stable_q);
                    press_valid_d = 1'b1;
                    press_code_d  = lowest_index(stable_q);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (stable_q == 4'b0000) begin
                    state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; synchronous active-low reset dominates everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q       <= 4'b0000;
            sync2_q       <= 4'b0000;
            stable_q      <= 4'b0000;
            cnt_q         <= '{default: '0};
            state_q       <= IDLE;
            button_out_q  <= 4'b0000;
            press_valid_q <= 1'b0;
            press_code_q  <= 2'd0;
            press_error_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            button_out_q  <= button_out_d;
            press_valid_q <= press_valid_d;
            press_code_q  <= press_code_d;
            press_error_q <= press_error_d;
        end
    end

    assign buttonOut  = button_out_q;
    assign pressValid = press_valid_q;
    assign pressCode  = press_code_q;
    assign pressError = press_error_q;
    assign busy       = (state_q == HELD);

endmodule

// File: tb/tb_button_debounce_encoder.sv
// Directed self-checking bench for button_debounce_encoder with DEBOUNCE_CYCLES = 4.
module tb_button_debounce_encoder;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] rawButton;
    logic [3:0] buttonOut;
    logic       pressValid;
    logic [1:0] pressCode;
    logic       pressError;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state, refreshed by clear_mon and updated by run_cycles.
    int         cyc;
    int         pulse_cnt;
    int         first_idx;
    logic [3:0] first_btn;
    logic [1:0] first_code;
    int         err_cnt;
    int         err_idx;
    int         busy_hi_idx;
    int         busy_lo_idx;
    int         inv_err = 0;

    button_debounce_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .rawButton  (rawButton),
        .buttonOut  (buttonOut),
        .pressValid (pressValid),
        .pressCode  (pressCode),
        .pressError (pressError),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_mon();
        cyc         = 0;
        pulse_cnt   = 0;
        first_idx   = -1;
        first_btn   = 4'b0000;
        first_code  = 2'd0;
        err_cnt     = 0;
        err_idx     = -1;
        busy_hi_idx = -1;
        busy_lo_idx = -1;
    endtask

    // Advance n edges; index k means the value observed just after edge Ek.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (pressValid) begin
                if (pulse_cnt == 0) begin
                    first_idx  = cyc;
                    first_btn  = buttonOut;
                    first_code = pressCode;
                end
                pulse_cnt++;
                if (buttonOut == 4'b0000) inv_err++;
            end else if ((buttonOut != 4'b0000) || (pressCode != 2'd0)) begin
                inv_err++;
            end
            if (pressError) begin
                if (err_cnt == 0) err_idx = cyc;
                err_cnt++;
            end
            if (busy && (busy_hi_idx < 0)) busy_hi_idx = cyc;
            if (!busy && (busy_lo_idx < 0)) busy_lo_idx = cyc;
            cyc++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        rawButton = 4'b0000;
        clear_mon();
        run_cycles(3);
        check_eq("reset_outputs", {27'd0, buttonOut, pressValid},      32'd0);
        check_eq("reset_misc",    {28'd0, pressCode, pressError, busy}, 32'd0);
        reset = 1'b1;
        run_cycles(2);

        // Clean single press on button 2.
        clear_mon();
        rawButton = 4'b0100;
        run_cycles(20);
        check_eq("single_count", pulse_cnt,  1);
        check_eq("single_edge",  first_idx,  N + 2);
        check_eq("single_btn",   first_btn,  4'b0100);
        check_eq("single_code",  first_code, 2'd2);
        check_eq("single_busy_rise", busy_hi_idx, N + 2);
        clear_mon();
        rawButton = 4'b0000;
        run_cycles(10);
        check_eq("release_busy_fall", busy_lo_idx, N + 2);
        check_eq("release_no_pulse",  pulse_cnt,   0);

        // Bounce rejection: three high cycles then one low, repeated.
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            rawButton = ((i % 4) != 3) ? 4'b0001 : 4'b0000;
            run_cycles(1);
        end
        check_eq("bounce_no_pulse", pulse_cnt, 0);
        rawButton = 4'b0001;
        run_cycles(20);
        check_eq("bounce_then_hold_count", pulse_cnt, 1);
        check_eq("bounce_then_hold_btn",   first_btn, 4'b0001);
        rawButton = 4'b0000;
        run_cycles(10);

        // Hold button 3, add button 1, then release both and press 1 alone.
        clear_mon();
        rawButton = 4'b1000;
        run_cycles(10);
        rawButton = 4'b1010;
        run_cycles(12);
        check_eq("lockout_count", pulse_cnt,  1);
        check_eq("lockout_btn",   first_btn,  4'b1000);
        check_eq("lockout_code",  first_code, 2'd3);
        rawButton = 4'b0000;
        run_cycles(10);
        check_eq("lockout_released", busy, 1'b0);
        clear_mon();
        rawButton = 4'b0010;
        run_cycles(10);
        check_eq("after_lockout_count", pulse_cnt,  1);
        check_eq("after_lockout_code",  first_code, 2'd1);
        check_eq("after_lockout_edge",  first_idx,  N + 2);
        rawButton = 4'b0000;
        run_cycles(10);

        // Simultaneous press of buttons 3 and 1.
        clear_mon();
        rawButton = 4'b1010;
        run_cycles(10);
`ifdef MULTI_PRESS_REJECT_EN
        check_eq("multi_no_valid",  pulse_cnt, 0);
        check_eq("multi_err_count", err_cnt,   1);
        check_eq("multi_err_edge",  err_idx,   N + 2);
`else
        check_eq("multi_count",  pulse_cnt,  1);
        check_eq("multi_btn",    first_btn,  4'b0010);
        check_eq("multi_code",   first_code, 2'd1);
        check_eq("multi_no_err", err_cnt,    0);
`endif
        check_eq("multi_busy", busy, 1'b1);
        rawButton = 4'b0000;
        run_cycles(10);

        // Reset asserted at edge E(N) in the middle of a debounce.
        clear_mon();
        rawButton = 4'b0100;
        run_cycles(N);
        reset = 1'b0;
        run_cycles(1);
        check_eq("midreset_no_pulse", pulse_cnt, 0);
        check_eq("midreset_outputs", {26'd0, buttonOut, pressValid, pressError, busy}, 32'd0);
        reset = 1'b1;
        clear_mon();
        run_cycles(12);
        check_eq("midreset_resume_count", pulse_cnt, 1);
        check_eq("midreset_resume_edge",  first_idx, N + 2);
        rawButton = 4'b0000;
        run_cycles(10);

        // Enable gating: button held and stable while disabled, reported on first enabled edge.
        clear_mon();
        enable    = 1'b0;
        rawButton = 4'b0100;
        run_cycles(12);
        check_eq("disabled_no_pulse", pulse_cnt, 0);
        check_eq("disabled_not_busy", busy,      1'b0);
        clear_mon();
        enable = 1'b1;
        run_cycles(3);
        check_eq("enable_count", pulse_cnt, 1);
        check_eq("enable_edge",  first_idx, 0);
        check_eq("enable_btn",   first_btn, 4'b0100);
        check_eq("enable_busy",  busy,      1'b1);
        rawButton = 4'b0000;
        run_cycles(10);

        check_eq("output_consistency", inv_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_debounce_encoder.md
# button_debounce_encoder

Input conditioner between the four raw push-buttons and the game core's `buttonIn[3:0]` port. It synchronises and debounces each button and emits exactly one single-cycle, one-hot press pulse per physical press. Further presses are locked out until every button has been released. The core's OR-of-buttons `ledOn` and `compareStage` logic therefore see one clean event per press instead of a bouncing level.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised button must differ from its stable value before the stable value flips. Legal range 2..65535.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the `clock` rising edge; 0 = reset.
- `enable` in 1: 1 = presses may be reported; 0 = reporting frozen (debounce keeps running).
- `rawButton` in 4: asynchronous, bouncing button levels; 1 = pressed.
- `buttonOut` out 4: one-hot press pulse, high for exactly one cycle; connects to the core's `buttonIn`.
- `pressValid` out 1: high in the same cycle as `buttonOut` is nonzero.
- `pressCode` out 2: index of the pressed button. Valid only while `pressValid` = 1; 0 otherwise.
- `pressError` out 1: one-cycle pulse on a rejected multi-button press. Tied 0 when `MULTI_PRESS_REJECT_EN` is undefined.
- `busy` out 1: 1 while in HELD (waiting for all buttons to be released).

## Operation
- **Synchroniser:** two flops per bit, `sync1 <= rawButton`, `sync2 <= sync1`.
- **Debounce (per bit i):**
  - Registers: `stable[i]` and counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync2[i] == stable[i]`, `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Otherwise `cnt[i] <= cnt[i] + 1`.
  - Any single cycle of agreement restarts the count, so bounces shorter than `DEBOUNCE_CYCLES` never flip `stable`.
- **FSM states:** IDLE and HELD.
  - IDLE, `enable` = 1, `stable` ≠ 0:
    - If exactly one bit i is set: register `buttonOut` = 1<<i, `pressValid` = 1, `pressCode` = i, then go to HELD.
    - If more than one bit is set: see Configuration, then go to HELD.
  - IDLE, `enable` = 0: stay in IDLE with no output. A button still held when `enable` rises is reported on the first enabled cycle.
  - HELD: stay until `stable` == 0, then go to IDLE. Presses and partial releases in HELD are ignored.
- **Registered outputs:** `buttonOut`, `pressValid`, `pressCode` and `pressError` are registered and default to 0 every cycle they are not asserted, so pulses are never wider than one cycle.
- **Reset values:** when `reset` = 0 at an edge, all of the following clear: sync flops, `stable`, `cnt`, state to IDLE, and all outputs to 0. Reset dominates every other event, including a press completing in the same cycle.

## Timing
- Let `rawButton[i]` rise cleanly before edge E0.
  - `sync2[i]` = 1 after E1.
  - The counter runs on edges E2..E(N+1) with N = `DEBOUNCE_CYCLES`.
  - `stable[i]` = 1 after E(N+1).
  - `pressValid` is high for the cycle following E(N+2), i.e. N+3 edges of latency.
- Release follows the same path: `stable` clears after E(N+1) relative to the release, `busy` drops after E(N+2), and the next press can be reported from E(N+3) onward.
- Buttons that stabilise on different edges are reported singly: the first one wins, and the later one is absorbed in HELD.
- There is no backpressure. The core must sample `buttonOut` every cycle.

## Configuration
- `MULTI_PRESS_REJECT_EN` defined: a multi-bit `stable` in IDLE produces `pressError` = 1 for one cycle, `pressValid` = 0, `buttonOut` = 0, then the FSM enters HELD.
- `MULTI_PRESS_REJECT_EN` undefined: the lowest set index wins. A normal pulse is issued for that button (e.g. `stable` = 4'b1010 → `buttonOut` = 4'b0010, `pressCode` = 1), and `pressError` is held at 0.

## Test plan
- **Clean single press:** N = 4; `rawButton` = 4'b0100 held for 20 cycles from E0 → `buttonOut` = 4'b0100, `pressCode` = 2 and `pressValid` for exactly one cycle after E6; `busy` = 1 from E6 until 6 edges after the release.
- **Bounce rejection:** N = 4; `rawButton[0]` toggles 1,1,1,0 repeatedly for 40 cycles → no pulse. It is then held at 1 → exactly one pulse.
- **Hold and lockout:** hold button 3, press button 1 while still holding 3 → one pulse for button 3 only. Release both, then press 1 → a pulse with `pressCode` = 1.
- **Simultaneous press:** `rawButton` = 4'b1010 at E0.
  - With the macro: `pressError` pulse after E(N+2), no `pressValid`.
  - Without it: `buttonOut` = 4'b0010.
- **Reset mid-operation:** drive `reset` = 0 at edge E(N) during a debounce → all outputs 0 and no pulse. Holding the button after `reset` returns to 1 yields a pulse N+3 edges later.
- **Enable gating:** `enable` = 0 while button 2 is held and stable. Raise `enable` → a pulse one edge later, then HELD.
